// File: rtl/tb_obi_pkg.sv
// Shared types for the testbench OBI RAM arbiter: port identifiers and the
// request/response bundles that travel between the core ports and the RAM.
package tb_obi_pkg;

    localparam int OBI_DATA_WIDTH = 32;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } obi_port_e;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      we;
        logic [3:0]                be;
        logic [OBI_DATA_WIDTH-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } obi_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the instruction port, bit 1 the data
// port; the priority pointer only moves when both inputs compete.
module rr_arb2
    import tb_obi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output obi_port_e  rr_o
);

    obi_port_e rr_q;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (rr_q == PORT_DATA) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // The favoured port hands priority to the other one after winning a contended cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= PORT_DATA;
        end else if (&req_i) begin
            rr_q <= (rr_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end
    end

    assign rr_o = rr_q;

endmodule

// File: rtl/tb_obi_ram_arbiter.sv
// Shares one single-port RAM between the instruction and data OBI ports,
// answers out-of-range addresses with an error and counts contended cycles.
module tb_obi_ram_arbiter
    import tb_obi_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [OBI_DATA_WIDTH-1:0] instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [31:0]               data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [OBI_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [OBI_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic                      ram_en_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [OBI_DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [OBI_DATA_WIDTH-1:0] ram_rdata_i,
    output logic [CNT_WIDTH-1:0]      contention_cnt_o
);

    if (DATA_WIDTH != OBI_DATA_WIDTH) begin : g_width_check
        $fatal(1, "tb_obi_ram_arbiter only supports DATA_WIDTH = 32");
    end

    logic [1:0]     gnt;
    obi_port_e      rr_state;
    obi_req_t       instr_req;
    obi_req_t       data_req;
    obi_req_t       sel_req;
    obi_port_e      sel_port;
    logic           granted;
    logic           in_range;

    logic           resp_valid_q;
    obi_port_e      resp_port_q;
    logic           resp_err_q;
    logic           resp_we_q;
    obi_rsp_t       rsp;
    obi_rsp_t       instr_rsp;
    obi_rsp_t       data_rsp;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 unused_sigs;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({data_req_i, instr_req_i}),
        .gnt_o (gnt),
        .rr_o  (rr_state)
    );

    assign instr_gnt_o = gnt[0];
    assign data_gnt_o  = gnt[1];

    always_comb begin
        instr_req = '{addr: instr_addr_i, we: 1'b0, be: 4'hF, wdata: '0};
        data_req  = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
        sel_req   = gnt[1] ? data_req : instr_req;
        sel_port  = gnt[1] ? PORT_DATA : PORT_INSTR;
        granted   = |gnt;
        in_range  = (sel_req.addr[31:RAM_ADDR_WIDTH] == '0);
    end

    // Out-of-range requests are still granted but never reach the RAM.
    assign ram_en_o    = granted & in_range;
    assign ram_addr_o  = sel_req.addr[RAM_ADDR_WIDTH-1:2];
    assign ram_we_o    = ram_en_o & sel_req.we;
    assign ram_be_o    = sel_req.be;
    assign ram_wdata_o = sel_req.wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_port_q  <= PORT_INSTR;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= granted;
            resp_port_q  <= sel_port;
            resp_err_q   <= ~in_range;
            resp_we_q    <= sel_req.we;
        end
    end

    // Gating with rst_i drops a response whose grant is followed by reset.
    always_comb begin
        rsp.rdata      = (resp_err_q || resp_we_q) ? '0 : ram_rdata_i;
        rsp.err        = resp_err_q;
        instr_rsp      = '0;
        data_rsp       = '0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        if (resp_valid_q && !rst_i) begin
            if (resp_port_q == PORT_DATA) begin
                data_rvalid_o = 1'b1;
                data_rsp      = rsp;
            end else begin
                instr_rvalid_o = 1'b1;
                instr_rsp      = rsp;
            end
        end
    end

    assign instr_rdata_o = instr_rsp.rdata;
    assign instr_err_o   = instr_rsp.err;
    assign data_rdata_o  = data_rsp.rdata;
    assign data_err_o    = data_rsp.err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (instr_req_i && data_req_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign contention_cnt_o = cnt_q;

    assign unused_sigs = ^{rr_state, sel_req.addr[1:0]};

endmodule

// File: tb/tb_tb_obi_ram_arbiter.sv
// Self-checking bench for tb_obi_ram_arbiter: directed vector table, a reset
// corner sequence and randomized traffic against a transaction-level model.
module tb_tb_obi_ram_arbiter;

    localparam int          AW        = 13;
    localparam int          WORDS     = 2 ** (AW - 2);
    localparam logic [31:0] RAM_BYTES = 32'(2 ** AW);

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwdata;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        igr;
        logic        dgr;
        logic        en;
        logic [31:0] raddr;
        logic        irv;
        logic        drv;
        logic        ierr;
        logic        derr;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        ram_en, ram_we;
    logic [AW-3:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] contention_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: transaction-level view of the arbiter and RAM.
    logic [31:0] m_mem [WORDS];
    bit          m_valid;
    bit          m_rr;
    bit          m_pend_valid;
    bit          m_pend_port;
    bit          m_pend_err;
    logic [31:0] m_pend_rdata;
    logic [31:0] m_cnt;

    logic [31:0] env_mem [WORDS];
    bit          env_init = 1'b0;

    always #5 clk = ~clk;

    tb_obi_ram_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .instr_req_i      (instr_req),
        .instr_gnt_o      (instr_gnt),
        .instr_addr_i     (instr_addr),
        .instr_rvalid_o   (instr_rvalid),
        .instr_rdata_o    (instr_rdata),
        .instr_err_o      (instr_err),
        .data_req_i       (data_req),
        .data_gnt_o       (data_gnt),
        .data_addr_i      (data_addr),
        .data_we_i        (data_we),
        .data_be_i        (data_be),
        .data_wdata_i     (data_wdata),
        .data_rvalid_o    (data_rvalid),
        .data_rdata_o     (data_rdata),
        .data_err_o       (data_err),
        .ram_en_o         (ram_en),
        .ram_addr_o       (ram_addr),
        .ram_we_o         (ram_we),
        .ram_be_o         (ram_be),
        .ram_wdata_o      (ram_wdata),
        .ram_rdata_i      (ram_rdata),
        .contention_cnt_o (contention_cnt)
    );

    function automatic logic [31:0] mem_init(input int i);
        return (i == 32'h20) ? 32'h0000_0013 : (32'hA500_0000 ^ (i * 32'h0001_0307));
    endfunction

    // Behavioural single-port RAM with one-cycle read latency; idle cycles return junk.
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < WORDS; i++) env_mem[i] <= mem_init(i);
            env_init <= 1'b1;
        end
        if (ram_en && !ram_we) begin
            ram_rdata <= env_mem[ram_addr];
        end else begin
            ram_rdata <= 32'hBAD0_0000 ^ $urandom;
        end
        if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) env_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mks(input logic r, input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic [31:0] da, input logic we,
                                  input logic [3:0] be, input logic [31:0] wd);
        stim_t s;
        s.rst = r; s.ireq = ir; s.iaddr = ia; s.dreq = dr; s.daddr = da;
        s.dwe = we; s.dbe = be; s.dwdata = wd;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic igr, input logic dgr, input logic en,
                                 input logic [31:0] raddr, input logic irv, input logic drv,
                                 input logic ierr, input logic derr, input logic [31:0] cnt);
        vec_t v;
        v.s = s; v.igr = igr; v.dgr = dgr; v.en = en; v.raddr = raddr;
        v.irv = irv; v.drv = drv; v.ierr = ierr; v.derr = derr; v.cnt = cnt;
        return v;
    endfunction

    // Drives one cycle, checks every output against the model, then advances the model.
    task automatic apply_stimulus(input stim_t s, output bit ig, output bit dg);
        logic [31:0] g_addr;
        bit          g_ok, een, irv, drv;
        int          w;
        @(negedge clk);
        rst        = s.rst;
        instr_req  = s.ireq;
        instr_addr = s.iaddr;
        data_req   = s.dreq;
        data_addr  = s.daddr;
        data_we    = s.dwe;
        data_be    = s.dbe;
        data_wdata = s.dwdata;
        #1;
        if (s.rst) begin
            ig = 1'b0;
            dg = 1'b0;
        end else begin
            dg = s.dreq && (!s.ireq || m_rr);
            ig = s.ireq && !dg;
        end
        g_addr = dg ? s.daddr : s.iaddr;
        g_ok   = g_addr < RAM_BYTES;
        een    = (ig || dg) && g_ok;
        w      = int'(g_addr[AW-1:2]);

        check_output("instr_gnt", instr_gnt, ig);
        check_output("data_gnt", data_gnt, dg);
        check_output("ram_en", ram_en, een);
        if (een) begin
            check_output("ram_addr", 32'(ram_addr), 32'(w));
            check_output("ram_we", ram_we, dg && s.dwe);
            check_output("ram_be", ram_be, dg ? s.dbe : 4'hF);
            if (dg && s.dwe) check_output("ram_wdata", ram_wdata, s.dwdata);
        end

        irv = !s.rst && m_pend_valid && !m_pend_port;
        drv = !s.rst && m_pend_valid && m_pend_port;
        check_output("instr_rvalid", instr_rvalid, irv);
        check_output("data_rvalid", data_rvalid, drv);
        check_output("instr_rdata", instr_rdata, irv ? m_pend_rdata : 32'h0);
        check_output("data_rdata", data_rdata, drv ? m_pend_rdata : 32'h0);
        check_output("instr_err", instr_err, irv && m_pend_err);
        check_output("data_err", data_err, drv && m_pend_err);
        if (m_valid) check_output("contention_cnt", contention_cnt, m_cnt);

        if (s.rst) begin
            m_valid      = 1'b1;
            m_pend_valid = 1'b0;
            m_rr         = 1'b1;
            m_cnt        = 32'h0;
        end else begin
            m_pend_valid = ig || dg;
            m_pend_port  = dg;
            m_pend_err   = !g_ok;
            m_pend_rdata = (!g_ok || (dg && s.dwe)) ? 32'h0 : m_mem[w];
            if (s.ireq && s.dreq) begin
                m_rr = !m_rr;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'h1;
            end
            if (dg && s.dwe && g_ok)
                for (int b = 0; b < 4; b++)
                    if (s.dbe[b]) m_mem[w][8*b +: 8] = s.dwdata[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        int w;
        r = $urandom_range(0, 7);
        if (r == 0) return RAM_BYTES + ($urandom & 32'h0FFF_FFFF);
        w = (r < 5) ? $urandom_range(0, 31) : $urandom_range(0, WORDS - 1);
        return 32'(w * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        vec_t  vecs[$];
        stim_t idle, both, s;
        bit    ig, dg, i_hold, d_hold;

        m_valid = 1'b0;
        m_rr = 1'b1;
        m_pend_valid = 1'b0;
        m_pend_port = 1'b0;
        m_pend_err = 1'b0;
        m_pend_rdata = 32'h0;
        m_cnt = 32'h0;
        for (int i = 0; i < WORDS; i++) m_mem[i] = mem_init(i);

        rst = 1'b1; instr_req = 1'b0; instr_addr = 32'h0; data_req = 1'b0;
        data_addr = 32'h0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;

        idle = mks(0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
        both = mks(0, 1, 32'h80, 1, 32'h100, 0, 4'hF, 32'h0);

        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(mks(1, 1, 32'h80, 1, 32'h100, 0, 4'hF, 32'h0), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(mks(0, 1, 32'h80, 0, 32'h0, 0, 4'h0, 32'h0), 1, 0, 1, 32'h20, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(both, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(both, 1, 0, 1, 32'h20, 0, 1, 0, 0, 1));
        vecs.push_back(mkv(both, 0, 1, 1, 32'h40, 1, 0, 0, 0, 2));
        vecs.push_back(mkv(both, 1, 0, 1, 32'h20, 0, 1, 0, 0, 3));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mkv(mks(0, 0, 32'h0, 1, 32'h100, 1, 4'h3, 32'hDEADBEEF), 0, 1, 1, 32'h40, 0, 0, 0, 0, 4));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(mkv(mks(0, 0, 32'h0, 1, 32'h2000, 0, 4'hF, 32'h0), 0, 1, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 0, 1, 0, 1, 4));
        vecs.push_back(mkv(mks(0, 0, 32'h0, 1, 32'h1FFC, 0, 4'hF, 32'h0), 0, 1, 1, 32'h7FF, 0, 0, 0, 0, 4));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        vecs.push_back(mkv(mks(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 4'h0, 32'h0), 1, 0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 1, 0, 1, 0, 4));
        vecs.push_back(mkv(mks(0, 0, 32'h0, 1, 32'h102, 0, 4'hF, 32'h0), 0, 1, 1, 32'h40, 0, 0, 0, 0, 4));
        vecs.push_back(mkv(idle, 0, 0, 0, 0, 0, 1, 0, 0, 4));

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].s, ig, dg);
            check_output($sformatf("vec%0d_igr", i), instr_gnt, vecs[i].igr);
            check_output($sformatf("vec%0d_dgr", i), data_gnt, vecs[i].dgr);
            check_output($sformatf("vec%0d_en", i), ram_en, vecs[i].en);
            if (vecs[i].en) check_output($sformatf("vec%0d_raddr", i), 32'(ram_addr), vecs[i].raddr);
            check_output($sformatf("vec%0d_irv", i), instr_rvalid, vecs[i].irv);
            check_output($sformatf("vec%0d_drv", i), data_rvalid, vecs[i].drv);
            check_output($sformatf("vec%0d_ierr", i), instr_err, vecs[i].ierr);
            check_output($sformatf("vec%0d_derr", i), data_err, vecs[i].derr);
            if (i > 0) check_output($sformatf("vec%0d_cnt", i), contention_cnt, vecs[i].cnt);
        end
        check_output("readback_after_write", data_rdata, (mem_init(32'h40) & 32'hFFFF_0000) | 32'h0000_BEEF);

        $display("[TB] reset after grant");
        apply_stimulus(both, ig, dg);
        check_output("rst_seq_first_data", data_gnt, 1'b1);
        apply_stimulus(mks(0, 1, 32'h80, 0, 32'h0, 0, 4'h0, 32'h0), ig, dg);
        check_output("rst_seq_instr_gnt", instr_gnt, 1'b1);
        apply_stimulus(mks(1, 0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0), ig, dg);
        check_output("rst_seq_no_rvalid", instr_rvalid, 1'b0);
        apply_stimulus(idle, ig, dg);
        check_output("rst_seq_still_no_rvalid", instr_rvalid, 1'b0);
        apply_stimulus(both, ig, dg);
        check_output("rst_seq_rr_data", data_gnt, 1'b1);
        check_output("rst_seq_rr_not_instr", instr_gnt, 1'b0);

        $display("[TB] randomized traffic");
        i_hold = 1'b0;
        d_hold = 1'b0;
        s = idle;
        for (int c = 0; c < 400; c++) begin
            s.rst = ($urandom_range(0, 49) == 0);
            if (!i_hold) begin
                s.ireq  = ($urandom_range(0, 2) != 0);
                s.iaddr = rand_addr();
            end
            if (!d_hold) begin
                s.dreq   = ($urandom_range(0, 2) != 0);
                s.daddr  = rand_addr();
                s.dwe    = $urandom_range(0, 1);
                s.dbe    = 4'($urandom_range(1, 15));
                s.dwdata = $urandom;
            end
            apply_stimulus(s, ig, dg);
            i_hold = s.ireq && !ig;
            d_hold = s.dreq && !dg;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_obi_ram_arbiter.md
Name: tb_obi_ram_arbiter

Overview:
Two-requester OBI arbiter that shares one single-port testbench RAM between the CV32E40X instruction and data interfaces inside the core testbench wrapper. It grants at most one request per cycle using round-robin on contention and routes the fixed 1-cycle RAM read response back to the granted port. It returns an error response for addresses outside the RAM and counts contention cycles for performance checks.

Parameters:
RAM_ADDR_WIDTH, 13, byte-address width of RAM; RAM holds 2**(RAM_ADDR_WIDTH-2) 32-bit words
DATA_WIDTH, 32, data width; fixed at 32, any other value triggers an elaboration $fatal
CNT_WIDTH, 32, width of the contention counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
instr_req_i  in  1  instruction request
instr_gnt_o  out  1  instruction grant (combinational)
instr_addr_i  in  32  instruction byte address
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction error (out of range)
data_req_i  in  1  data request
data_gnt_o  out  1  data grant (combinational)
data_addr_i  in  32  data byte address
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_wdata_i  in  32  data write data
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
data_err_o  out  1  data error
ram_en_o  out  1  RAM access enable
ram_addr_o  out  RAM_ADDR_WIDTH-2  RAM word address
ram_we_o  out  1  RAM write enable
ram_be_o  out  4  RAM byte enables
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data; valid exactly 1 cycle after ram_en_o
contention_cnt_o  out  CNT_WIDTH  count of cycles with both requests high

Behaviour:
- Single clock clk_i. rst_i is synchronous and active-high; all state is cleared on the clk_i edge where rst_i=1.
- Reset values: rvalid/err = 0 on both ports, rdata = 0 on both ports, rr_q = DATA, contention_cnt_o = 0.
- While rst_i=1: both gnt = 0 and ram_en_o = 0, regardless of requests.
- Arbitration is evaluated combinationally every cycle:
  - Only one req high: grant that port.
  - Both high: grant the port held in rr_q. After the grant, rr_q updates to the other port.
  - No req high: no grant. rr_q holds.
  - Never assert gnt without the matching req.
- A requester that loses arbitration keeps req, address and attributes stable until granted. The arbiter never drops a pending request.
- Address check: a request is in range when addr < 2**RAM_ADDR_WIDTH.
  - In range and granted: ram_en_o=1 in the same cycle.
  - ram_addr_o = addr[RAM_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - Instruction port: ram_we_o=0, ram_be_o=4'hF.
  - Data port: ram_we_o, ram_be_o and ram_wdata_o follow the data inputs.
- Out of range and granted: the request is still granted, ram_en_o=0, and the write is dropped.
- Response timing:
  - Exactly 1 cycle after each grant, rvalid pulses for one cycle on the granted port.
  - err = 1 if the request was out of range.
  - rdata = ram_rdata_i for an in-range read. rdata = 0 for writes and for errors.
  - Track this with registered resp_valid_q, resp_port_q, resp_err_q and resp_we_q.
- Throughput is one grant per cycle. A grant and the previous grant's response may occur in the same cycle, on the same or different ports.
- When no response is pending, rvalid/err = 0 and rdata = 0 on both ports.
- contention_cnt_o increments in every non-reset cycle with both reqs high and saturates at all-ones.
- Reset asserted the cycle after a grant: the pending response is discarded and no rvalid is produced.

Decomposition:
- Package tb_obi_pkg:
  - enum obi_port_e {PORT_INSTR=0, PORT_DATA=1}
  - struct obi_req_t {addr, we, be, wdata}
  - struct obi_rsp_t {rdata, err}
  - constant OBI_DATA_WIDTH = 32
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Ports: clk_i, rst_i, req_i[1:0], gnt_o[1:0], rr state.
  - Reused by the top module for the grant decision.

Test Plan:
1. Reset: rst_i=1 for 3 cycles with both reqs high -> no gnt, ram_en_o=0, contention_cnt_o=0, no rvalid.
2. Instruction read alone: instr_addr=0x80 -> instr_gnt same cycle, ram_addr_o=0x20, ram_be_o=0xF. RAM returns 0x00000013 -> next cycle instr_rvalid=1, rdata=0x13, err=0.
3. Contention: both reqs held for 4 cycles after reset -> grants D,I,D,I; contention_cnt_o=4; each response arrives 1 cycle later on the correct port.
4. Data write: addr=0x100, be=0x3, wdata=0xDEADBEEF -> ram_en=1, we=1, ram_addr_o=0x40, be=0x3. Next cycle data_rvalid=1, err=0, rdata=0.
5. Out of range: data read addr=0x2000 -> data_gnt=1, ram_en_o=0. Next cycle data_rvalid=1, err=1, rdata=0.
6. Reset after grant: instruction granted in cycle N, rst_i=1 in cycle N+1 -> instr_rvalid stays 0 and rr_q returns to DATA.
